key_debounce_fsm: RTL
=====================

# key_debounce_fsm

Debounces one raw mechanical push-button into a clean level plus single-cycle press/release strobes, all in the system clock domain. It sits directly upstream of the manual-clock shift-register stage. `key_level` is the clean edge that stage clocks on. `key_press` serves synchronous consumers that prefer a clock-enable. Bounces shorter than the stability window are rejected entirely.

## Interface
- `STABLE_CYCLES`, default 2_000_000: consecutive identical synchronized samples required to accept a transition (20 ms at 100 MHz); must be ≥2.
- `REPEAT_DELAY`, default 50_000_000: cycles in HELD before the first `key_repeat` pulse (repeat build only).
- `REPEAT_PERIOD`, default 10_000_000: cycles between subsequent `key_repeat` pulses (repeat build only).
- `clk` input 1: system clock.
- `reset` input 1: reset, asynchronous, active-high.
- `key_in` input 1: raw button, asynchronous, active-high, bouncy.
- `key_level` output 1: debounced level; drives the downstream shift-register clock.
- `key_press` output 1: one-cycle pulse on accepted press.
- `key_release` output 1: one-cycle pulse on accepted release.
- `key_repeat` output 1: one-cycle auto-repeat pulse while held; constant 0 when the feature is compiled out.

## Operation
- `key_in` → 2-FF synchronizer → `key_s`. The FSM sees only `key_s`.
- States and transitions:
  - IDLE: `key_s`=1 → PRESS_WAIT, with `cnt`←0.
  - PRESS_WAIT: `key_s`=0 → IDLE (bounce rejected). `key_s`=1 and `cnt`==STABLE_CYCLES-1 → HELD. Otherwise `cnt`++.
  - HELD: `key_s`=0 → RELEASE_WAIT, with `cnt`←0.
  - RELEASE_WAIT: `key_s`=1 → HELD (bounce rejected; the repeat timer restarts). `key_s`=0 and `cnt`==STABLE_CYCLES-1 → IDLE. Otherwise `cnt`++.
- Outputs are registered:
  - `key_level`=1 exactly in HELD and RELEASE_WAIT.
  - `key_press` pulses on the PRESS_WAIT→HELD transition.
  - `key_release` pulses on the RELEASE_WAIT→IDLE transition.
- One shared counter serves both debounce and repeat. Its width is `$clog2` of the largest active parameter + 1. It is cleared on every state change and never wraps: the comparisons fire before overflow.
- `key_press`, `key_release` and `key_repeat` are mutually exclusive; at most one is high in any cycle.
- Reset, asynchronous at any point including mid-count:
  - State returns to IDLE.
  - `cnt`, the synchronizer flops and all outputs go to 0.
  - A button held through reset deassertion is accepted as a fresh press after the full window.

## Timing
- Reset values: `key_level`=0, `key_press`=0, `key_release`=0, `key_repeat`=0.
- Press latency: with `key_in` clean high from edge 0, `key_s`=1 after edge 2. PRESS_WAIT is entered at edge 3. `key_level`↑ and the `key_press` pulse appear after edge STABLE_CYCLES+3, and `key_press` stays high for exactly 1 cycle.
- Release latency is symmetric: STABLE_CYCLES+3 cycles from a clean `key_in`↓ to `key_level`↓ and the `key_release` pulse.
- Any `key_s` glitch shorter than STABLE_CYCLES cycles produces no output change.
- Minimum accepted press-to-release spacing is therefore STABLE_CYCLES+1 synchronized cycles in each state.

## Configuration
- `KEY_DEBOUNCE_REPEAT_EN` defined:
  - In HELD, `cnt` counts. `key_repeat` pulses when `cnt` reaches REPEAT_DELAY-1.
  - Thereafter `key_repeat` pulses every REPEAT_PERIOD cycles (`cnt` reloads to 0 at each pulse) for as long as the FSM remains in HELD.
  - Entering RELEASE_WAIT stops repeats.
- `KEY_DEBOUNCE_REPEAT_EN` undefined: the port is tied to 0, the repeat compare logic is absent, and `cnt` is idle in HELD.

## Structure
- Package `key_debounce_pkg` holds:
  - the state typedef `kd_state_t` {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}, 2-bit encoding;
  - default constants `KD_STABLE_CYCLES_DEF`, `KD_REPEAT_DELAY_DEF`, `KD_REPEAT_PERIOD_DEF`.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with asynchronous reset to 0, reusable for other front-panel inputs.

## Test plan
- Use STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 on the bench.
- Clean press held 20 cycles → `key_level`↑ and one `key_press` pulse 7 cycles after `key_in`↑; no `key_release`.
- Bounce 1,0,1,0 at 1-cycle spacing, then steady 1 → no output until the steady run completes; then exactly one `key_press`, 7 cycles after the last `key_in`↑.
- Release with a 2-cycle high glitch during RELEASE_WAIT → `key_level` stays 1 through the glitch; `key_release` occurs once, 7 cycles after the final `key_in`↓.
- Reset asserted mid-PRESS_WAIT while `key_in`=1 → all outputs 0 immediately; after deassertion, `key_press` arrives after a full 7-cycle window.
- `KEY_DEBOUNCE_REPEAT_EN` build, hold 30 cycles past `key_press`:
  - `key_repeat` pulses at 10, 13, 16, 19, … cycles after `key_press`;
  - no pulses after the release starts;
  - non-repeat build shows `key_repeat`=0 throughout.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } kd_state_t;

  localparam int KD_STABLE_CYCLES_DEF = 2_000_000;
  localparam int KD_REPEAT_DELAY_DEF  = 50_000_000;
  localparam int KD_REPEAT_PERIOD_DEF = 10_000_000;

  function automatic int kd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous front-panel inputs; clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_debounce_fsm.sv
// Push-button debouncer: clean level plus press/release strobes.
// Define KEY_DEBOUNCE_REPEAT_EN to build the auto-repeat pulse generator.
module key_debounce_fsm
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = KD_STABLE_CYCLES_DEF,
  parameter int REPEAT_DELAY  = KD_REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = KD_REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int CNT_MAX = kd_max(STABLE_CYCLES, kd_max(REPEAT_DELAY, REPEAT_PERIOD));
`else
  localparam int CNT_MAX = STABLE_CYCLES;
`endif
  localparam int CNT_W = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic key_s;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (key_in),
    .q     (key_s)
  );

  kd_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_d;

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  // armed_q: first repeat already issued, later pulses use the shorter period
  logic             repeat_q;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] rep_last;

  assign rep_last = armed_q ? PERIOD_LAST : DELAY_LAST;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (key_s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
          if (cnt_q == rep_last) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

`ifdef KEY_DEBOUNCE_REPEAT_EN
  // Leaving HELD, even briefly on a release bounce, restarts the initial delay
  always_comb begin
    armed_d = armed_q;
    if (repeat_d)              armed_d = 1'b1;
    else if (state_d != HELD)  armed_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      repeat_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
      armed_q  <= armed_d;
    end
  end

  assign key_repeat = repeat_q;
`else
  assign key_repeat = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule
